// File: rtl/wisc_pkg.sv
// Shared WISC control definitions: opcodes, zero register, per-stage control bundles.
// Optional HLT support is selected elsewhere with CTRL_PIPE_HALT_EN.
package wisc_pkg;

    localparam int OPW  = 4;
    localparam int RW   = 4;
    localparam int ALUW = 3;

    localparam logic [OPW-1:0] OP_ADD    = 4'h0;
    localparam logic [OPW-1:0] OP_SUB    = 4'h1;
    localparam logic [OPW-1:0] OP_XOR    = 4'h2;
    localparam logic [OPW-1:0] OP_RED    = 4'h3;
    localparam logic [OPW-1:0] OP_SLL    = 4'h4;
    localparam logic [OPW-1:0] OP_SRA    = 4'h5;
    localparam logic [OPW-1:0] OP_ROR    = 4'h6;
    localparam logic [OPW-1:0] OP_PADDSB = 4'h7;
    localparam logic [OPW-1:0] OP_LW     = 4'h8;
    localparam logic [OPW-1:0] OP_SW     = 4'h9;
    localparam logic [OPW-1:0] OP_LHB    = 4'hA;
    localparam logic [OPW-1:0] OP_LLB    = 4'hB;
    localparam logic [OPW-1:0] OP_B      = 4'hC;
    localparam logic [OPW-1:0] OP_BR     = 4'hD;
    localparam logic [OPW-1:0] OP_PCS    = 4'hE;
    localparam logic [OPW-1:0] OP_HLT    = 4'hF;

    localparam logic [RW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ALUW-1:0] alu_op;
        logic            alu_src;
        logic            shift;
        logic            modify;
        logic            mem;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic            valid;
        ex_ctrl_t        ex;
        mem_ctrl_t       mem;
        wb_ctrl_t        wb;
        logic [RW-1:0]   rd;
    } id_ex_t;

    typedef struct packed {
        logic            valid;
        mem_ctrl_t       mem;
        wb_ctrl_t        wb;
        logic [RW-1:0]   rd;
    } ex_mem_t;

    typedef struct packed {
        logic            valid;
        wb_ctrl_t        wb;
        logic [RW-1:0]   rd;
    } mem_wb_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational WISC opcode decode into EX/MEM/WB control bundles and source usage.
// With CTRL_PIPE_HALT_EN defined, opcode F additionally raises the halt flag.
module ctrl_decode
    import wisc_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    input  logic [RW-1:0]  rd,
    input  logic [RW-1:0]  rt,
    output ex_ctrl_t       ex_ctrl,
    output mem_ctrl_t      mem_ctrl,
    output wb_ctrl_t       wb_ctrl,
    output logic           rs_used,
    output logic [RW-1:0]  src2,
    output logic           src2_used
`ifdef CTRL_PIPE_HALT_EN
    ,
    output logic           halt
`endif
);

    logic mem_op;
    logic modify;

    always_comb begin
        mem_op = (opcode == OP_LW) || (opcode == OP_SW);
        modify = (opcode == OP_LHB) || (opcode == OP_LLB);

        // Opcode F carries no controls in either build; only the halt flag differs.
        ex_ctrl.alu_op  = (mem_op || opcode == OP_HLT) ? '0 : opcode[ALUW-1:0];
        ex_ctrl.alu_src = mem_op;
        ex_ctrl.shift   = opcode inside {OP_SLL, OP_SRA, OP_ROR};
        ex_ctrl.modify  = modify;
        ex_ctrl.mem     = mem_op;

        mem_ctrl.mem_read  = (opcode == OP_LW);
        mem_ctrl.mem_write = (opcode == OP_SW);

        wb_ctrl.reg_write  = (opcode inside {OP_LW, OP_LHB, OP_LLB, OP_PCS})
                           || (!opcode[OPW-1] && rd != ZERO_REG);
        wb_ctrl.mem_to_reg = (opcode == OP_LW);

        rs_used   = (opcode <= OP_SW) || (opcode == OP_BR);
        src2      = (mem_op || modify) ? rd : rt;
        src2_used = opcode inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB,
                                   OP_SW, OP_LHB, OP_LLB};
    end

`ifdef CTRL_PIPE_HALT_EN
    assign halt = (opcode == OP_HLT) && (OP_B != OP_HLT);
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined WISC control: ID/EX, EX/MEM, MEM/WB control registers with load-use,
// stall and flush handling. CTRL_PIPE_HALT_EN adds HLT tracking and the halted port.
module ctrl_pipe
    import wisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [OPW-1:0]  id_opcode,
    input  logic [RW-1:0]   id_rd,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            mem_stall,
    input  logic            flush,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [ALUW-1:0] ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_shift,
    output logic            ex_modify,
    output logic            ex_mem,
    output logic [RW-1:0]   ex_rd,
    output logic            mem_valid,
    output logic            mem_read,
    output logic            mem_write,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic [RW-1:0]   wb_rd
`ifdef CTRL_PIPE_HALT_EN
    ,
    output logic            halted
`endif
);

    ex_ctrl_t      dec_ex;
    mem_ctrl_t     dec_mem;
    wb_ctrl_t      dec_wb;
    logic          rs_used;
    logic          src2_used;
    logic [RW-1:0] src2;

    id_ex_t  id_stage, ex_q, ex_d;
    ex_mem_t mem_q, mem_d;
    mem_wb_t wb_q, wb_d;

`ifdef CTRL_PIPE_HALT_EN
    logic dec_halt;
    logic ex_halt_q, ex_halt_d;
    logic mem_halt_q, mem_halt_d;
    logic halted_q, halted_d;
`endif

    ctrl_decode u_decode (
        .opcode    (id_opcode),
        .rd        (id_rd),
        .rt        (id_rt),
        .ex_ctrl   (dec_ex),
        .mem_ctrl  (dec_mem),
        .wb_ctrl   (dec_wb),
        .rs_used   (rs_used),
        .src2      (src2),
        .src2_used (src2_used)
`ifdef CTRL_PIPE_HALT_EN
        ,
        .halt      (dec_halt)
`endif
    );

    // A load in EX whose destination feeds the ID instruction must be waited on once.
    assign hazard_stall = id_valid && ex_q.valid && ex_q.mem.mem_read
                       && (ex_q.rd != ZERO_REG)
                       && ((rs_used && ex_q.rd == id_rs) || (src2_used && ex_q.rd == src2));

    always_comb begin
        // NOTE: every signal gets a default before any branch; a missed path would infer a latch.
        id_stage = '0;
        if (id_valid) begin
            id_stage.valid = 1'b1;
            id_stage.ex    = dec_ex;
            id_stage.mem   = dec_mem;
            id_stage.wb    = dec_wb;
            id_stage.rd    = id_rd;
        end

        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_stall) begin
            ex_d        = (flush || hazard_stall) ? '0 : id_stage;
            mem_d.valid = ex_q.valid;
            mem_d.mem   = ex_q.mem;
            mem_d.wb    = ex_q.wb;
            mem_d.rd    = ex_q.rd;
            wb_d.valid  = mem_q.valid;
            wb_d.wb     = mem_q.wb;
            wb_d.rd     = mem_q.rd;
        end

`ifdef CTRL_PIPE_HALT_EN
        if (halted_q) begin
            ex_d  = '0;
            mem_d = '0;
            wb_d  = '0;
        end
`endif
    end

`ifdef CTRL_PIPE_HALT_EN
    always_comb begin
        ex_halt_d  = ex_halt_q;
        mem_halt_d = mem_halt_q;
        if (!mem_stall) begin
            ex_halt_d  = dec_halt && id_valid && !flush && !hazard_stall;
            mem_halt_d = ex_halt_q;
        end
        // HLT entering WB sets the sticky flag on the same edge.
        halted_d = halted_q || (!mem_stall && mem_halt_q);
        if (halted_q) begin
            ex_halt_d  = 1'b0;
            mem_halt_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_halt_q  <= 1'b0;
            mem_halt_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            ex_halt_q  <= ex_halt_d;
            mem_halt_q <= mem_halt_d;
            halted_q   <= halted_d;
        end
    end

    assign halted = halted_q;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignment so every stage samples pre-edge values.
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.ex.alu_op;
    assign ex_alu_src    = ex_q.ex.alu_src;
    assign ex_shift      = ex_q.ex.shift;
    assign ex_modify     = ex_q.ex.modify;
    assign ex_mem        = ex_q.ex.mem;
    assign ex_rd         = ex_q.rd;
    assign mem_valid     = mem_q.valid;
    assign mem_read      = mem_q.mem.mem_read;
    assign mem_write     = mem_q.mem.mem_write;
    assign wb_valid      = wb_q.valid;
    assign wb_reg_write  = wb_q.wb.reg_write;
    assign wb_mem_to_reg = wb_q.wb.mem_to_reg;
    assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: the driver pushes one expected EX entry per advancing
// edge from a table-driven ISA model; a monitor pops and checks all stage outputs.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_opcode = '0, id_rd = '0, id_rs = '0, id_rt = '0;
    logic       mem_stall = 1'b0, flush = 1'b0;
    logic       hazard_stall, ex_valid, ex_alu_src, ex_shift, ex_modify, ex_mem;
    logic [2:0] ex_alu_op;
    logic [3:0] ex_rd, wb_rd;
    logic       mem_valid, mem_read, mem_write, wb_valid, wb_reg_write, wb_mem_to_reg;
`ifdef CTRL_PIPE_HALT_EN
    logic       halted;
`endif

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .mem_stall(mem_stall), .flush(flush),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_shift(ex_shift), .ex_modify(ex_modify), .ex_mem(ex_mem),
        .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd(wb_rd)
`ifdef CTRL_PIPE_HALT_EN
        , .halted(halted)
`endif
    );

    typedef struct packed {
        logic       valid;
        logic [2:0] alu_op;
        logic       alu_src, shift, modify, mem_op;
        logic       mem_read, mem_write, reg_write, mem_to_reg;
        logic [3:0] rd;
        logic       rs_used, src2_used;
        logic [3:0] rs, src2;
    } inst_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    inst_t exp_q[$];
    inst_t ex_model = '0;
    logic  model_halted = 1'b0;

`ifdef CTRL_PIPE_HALT_EN
    localparam int MAX_OP = 14;
`else
    localparam int MAX_OP = 15;
`endif

    // ISA decode table, one row per opcode.
    function automatic inst_t ref_decode(input logic [3:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs, input logic [3:0] rt);
        inst_t r = '0;
        r.valid = 1'b1; r.rd = rd; r.rs = rs; r.src2 = rt;
        case (op)
            4'h0: begin r.alu_op = 3'd0; r.rs_used = 1; r.src2_used = 1; r.reg_write = (rd != 0); end
            4'h1: begin r.alu_op = 3'd1; r.rs_used = 1; r.src2_used = 1; r.reg_write = (rd != 0); end
            4'h2: begin r.alu_op = 3'd2; r.rs_used = 1; r.src2_used = 1; r.reg_write = (rd != 0); end
            4'h3: begin r.alu_op = 3'd3; r.rs_used = 1; r.src2_used = 1; r.reg_write = (rd != 0); end
            4'h4: begin r.alu_op = 3'd4; r.shift = 1; r.rs_used = 1; r.reg_write = (rd != 0); end
            4'h5: begin r.alu_op = 3'd5; r.shift = 1; r.rs_used = 1; r.reg_write = (rd != 0); end
            4'h6: begin r.alu_op = 3'd6; r.shift = 1; r.rs_used = 1; r.reg_write = (rd != 0); end
            4'h7: begin r.alu_op = 3'd7; r.rs_used = 1; r.src2_used = 1; r.reg_write = (rd != 0); end
            4'h8: begin r.alu_src = 1; r.mem_op = 1; r.mem_read = 1; r.mem_to_reg = 1;
                        r.reg_write = 1; r.rs_used = 1; r.src2 = rd; end
            4'h9: begin r.alu_src = 1; r.mem_op = 1; r.mem_write = 1; r.rs_used = 1;
                        r.src2_used = 1; r.src2 = rd; end
            4'hA: begin r.alu_op = 3'd2; r.modify = 1; r.reg_write = 1; r.src2_used = 1; r.src2 = rd; end
            4'hB: begin r.alu_op = 3'd3; r.modify = 1; r.reg_write = 1; r.src2_used = 1; r.src2 = rd; end
            4'hC: begin r.alu_op = 3'd4; end
            4'hD: begin r.alu_op = 3'd5; r.rs_used = 1; end
            4'hE: begin r.alu_op = 3'd6; r.reg_write = 1; end
            default: begin end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: a new EX entry appears on every advancing edge; older entries move down.
    initial begin : monitor
        inst_t cur_ex, cur_mem, cur_wb;
        logic  rst_seen, adv;
        cur_ex = '0; cur_mem = '0; cur_wb = '0;
        forever begin
            @(posedge clk);
            rst_seen = !rst_n;
            adv      = !mem_stall;
            @(negedge clk);
            if (rst_seen) begin
                cur_ex = '0; cur_mem = '0; cur_wb = '0;
            end else if (adv) begin
                cur_wb  = cur_mem;
                cur_mem = cur_ex;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard_empty at %0t: DUT advanced with no expected entry", $time);
                    cur_ex = '0;
                end else begin
                    cur_ex = exp_q.pop_front();
                end
            end
            check("ex_stage",
                  {20'd0, ex_valid, ex_alu_op, ex_alu_src, ex_shift, ex_modify, ex_mem, ex_rd},
                  {20'd0, cur_ex.valid, cur_ex.alu_op, cur_ex.alu_src, cur_ex.shift,
                   cur_ex.modify, cur_ex.mem_op, cur_ex.rd});
            check("mem_stage", {29'd0, mem_valid, mem_read, mem_write},
                  {29'd0, cur_mem.valid, cur_mem.mem_read, cur_mem.mem_write});
            check("wb_stage", {25'd0, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd},
                  {25'd0, cur_wb.valid, cur_wb.reg_write, cur_wb.mem_to_reg, cur_wb.rd});
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // One ID cycle: drive, check hazard_stall, then record what the edge loads into EX.
    task automatic issue(input logic v, input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [3:0] rt,
                         input logic fl, input logic ms, output logic accepted);
        inst_t d, nxt;
        logic  exp_hz;
        id_valid = v; id_opcode = op; id_rd = rd; id_rs = rs; id_rt = rt;
        flush = fl; mem_stall = ms;
        d = ref_decode(op, rd, rs, rt);
        exp_hz = v && ex_model.valid && ex_model.mem_read && (ex_model.rd != 0)
              && ((d.rs_used && ex_model.rd == rs) || (d.src2_used && ex_model.rd == d.src2));
        @(negedge clk);
        check("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_hz});
        @(posedge clk);
        accepted = 1'b0;
        if (!ms) begin
            nxt = (model_halted || fl || exp_hz || !v) ? '0 : d;
            exp_q.push_back(nxt);
            ex_model = nxt;
            accepted = !exp_hz || fl || model_halted;
        end
        #1;
    endtask

    // Present an instruction until the model says it entered EX (replays after load-use).
    task automatic send(input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] rs, input logic [3:0] rt);
        logic acc;
        int   tries = 0;
        do begin
            issue(1'b1, op, rd, rs, rt, 1'b0, 1'b0, acc);
            tries++;
        end while (!acc && tries < 3);
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL replay_bound at %0t: opcode %0h never accepted", $time, op);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) issue(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, acc);
    endtask

    task automatic do_reset();
        id_valid = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ex_model = '0;
        model_halted = 1'b0;
        exp_q.delete();
    endtask

    initial begin : stimulus
        logic acc;
        do_reset();

        for (int op = 0; op <= MAX_OP; op++) send(4'(op), 4'd3, 4'd1, 4'd2);
        send(4'h0, 4'd0, 4'd1, 4'd2);
        idle(4);

        // Load-use with a single bubble, then non-hazards.
        send(4'h8, 4'd5, 4'd1, 4'd0);
        send(4'h0, 4'd6, 4'd5, 4'd2);
        send(4'h8, 4'd5, 4'd1, 4'd0);
        send(4'h4, 4'd6, 4'd2, 4'd5);
        send(4'h8, 4'd0, 4'd1, 4'd0);
        send(4'h0, 4'd6, 4'd0, 4'd0);
        idle(3);

        // Flush of a store, and flush coinciding with a load-use hazard.
        issue(1'b1, 4'h9, 4'd3, 4'd1, 4'd0, 1'b1, 1'b0, acc);
        send(4'h8, 4'd5, 4'd1, 4'd0);
        issue(1'b1, 4'h0, 4'd6, 4'd5, 4'd2, 1'b1, 1'b0, acc);
        send(4'h2, 4'd4, 4'd1, 4'd2);
        idle(3);

        // mem_stall for three cycles with a load in MEM.
        send(4'h8, 4'd7, 4'd1, 4'd0);
        send(4'h0, 4'd1, 4'd2, 4'd3);
        for (int i = 0; i < 3; i++) issue(1'b1, 4'h1, 4'd2, 4'd7, 4'd7, 1'b0, 1'b1, acc);
        idle(4);

        // Mid-stream reset.
        send(4'h8, 4'd2, 4'd1, 4'd0);
        send(4'hA, 4'd3, 4'd0, 4'd0);
        do_reset();
        idle(2);

        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 3) != 0, 4'($urandom_range(0, MAX_OP)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, acc);
            if (i % 97 == 50) do_reset();
        end
        idle(4);

`ifdef CTRL_PIPE_HALT_EN
        do_reset();
        send(4'hF, 4'd0, 4'd0, 4'd0);
        idle(2);
        check("halted_set", {31'd0, halted}, 32'd1);
        model_halted = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 4'h0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0, acc);
            check("halted_sticky", {31'd0, halted}, 32'd1);
        end
        do_reset();
        check("halted_reset", {31'd0, halted}, 32'd0);
        idle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
